avr_progmem: RTL
================

// Module: avr_progmem
// PURPOSE
// Program-memory responder for the avr core. It serves the core's fetch bus: the core drives pc,
// and this block returns flash combinationally in the same cycle.
// It also hosts a byte-stream loader (fed from a UART receiver) that rewrites program memory at
// run time. While loading, the core is halted through cpu_run, which drives the core's locked.
// After a load, the block restarts the core at address 0 by injecting one RJMP.
// PARAMETERS
// ADDR_W   9          fetch address width; DEPTH = 2**ADDR_W words (512)
// TIMEOUT  1000000    max idle clocks between loader bytes before abort; counter is 20 bits
// HDR      8'hA5      load-frame start byte
// PORTS
// clock      in   1       system clock, all state on posedge
// reset_n    in   1       asynchronous, active-low reset
// pc         in   ADDR_W  fetch address from core
// flash      out  16      instruction word for pc (combinational)
// cpu_run    out  1       to core locked; 1 = core executes
// rx_data    in   8       loader byte
// rx_valid   in   1       rx_data valid; byte accepted when rx_valid & rx_ready
// rx_ready   out  1       loader can accept a byte
// load_busy  out  1       1 while a frame is in progress
// load_done  out  1       1-clock pulse on a good frame
// load_err   out  1       sticky error; cleared by reset or next accepted HDR
// BEHAVIOUR
// - Frame format: HDR, CNT_L, CNT_H, then CNT words each sent lo-byte then hi-byte, then CSUM.
// - CNT range is 1..DEPTH. CSUM = 8-bit sum (mod 256) of all data bytes.
// - Memory: DEPTH x 16 array, async read. It is not cleared by reset; its power-up content is 0.
// - FSM states: BOOT, RUN, CNTL, CNTH, LO, HI, CSUM, ERR. Reset enters BOOT.
// - Reset values: cpu_run=1, load_busy=0, load_done=0, load_err=0, word/count/sum/timer regs=0.
// - BOOT:
//   - flash = {4'hC, 3'b000, ~pc}, i.e. an RJMP such that pc + k + 1 = 0 (mod 512).
//   - cpu_run=1 and rx_ready=0.
//   - Next state is RUN; BOOT lasts exactly 1 clock.
// - RUN:
//   - flash = mem[pc], cpu_run=1, rx_ready=1.
//   - An accepted byte equal to HDR: load_err<=0, sum<=0, waddr<=0, go to CNTL.
//   - Any other accepted byte is discarded.
// - CNTL, CNTH, LO, HI, CSUM:
//   - cpu_run=0, load_busy=1, rx_ready=1.
//   - flash = mem[pc]; the core is stalled, so this value is ignored.
// - CNTL: accepted byte goes to cnt[7:0], then CNTH.
// - CNTH: accepted byte goes to cnt[15:8].
//   - If the full count is 0 or >DEPTH, go to ERR on that same clock edge.
//   - Otherwise go to LO.
// - LO: accepted byte is latched as lo; sum += byte; go to HI.
// - HI: on the accepted byte:
//   - mem[waddr] <= {byte, lo}; sum += byte; waddr++; remaining count decrements.
//   - If the remaining count reaches 0, go to CSUM; otherwise go to LO.
// - CSUM: on the accepted byte:
//   - If it equals sum: load_done=1 for 1 clock, go to BOOT.
//   - If not: go to ERR.
//   - Words already written stay written in either case.
// - ERR:
//   - load_err=1, cpu_run=0, load_busy=0, rx_ready=1.
//   - An accepted HDR restarts the frame (as from RUN). Other bytes are ignored.
//   - The core stays halted until a good frame completes.
// - Timeout:
//   - In CNTL..CSUM, the timer increments on every clock with no accepted byte.
//   - The timer clears on each accepted byte.
//   - When the timer reaches TIMEOUT-1, go to ERR.
//   - If a byte arrives on the expiry clock, the byte wins.
// - waddr wraps modulo DEPTH. This cannot occur, because CNT <= DEPTH.
// - Reset asserted mid-frame: immediately enter BOOT state values; the partial memory content is kept.
// - load_busy and cpu_run are mutually exclusive outside BOOT/RUN/ERR.
// TESTING
// - Reset release with pc=9'h1F3: flash=16'hC00C for 1 clock, cpu_run=1.
//   Next clock flash=mem[9'h1F3]=0.
// - Frame A5 02 00 34 12 78 56 14: mem[0]=1234, mem[1]=5678, load_done pulse, load_err=0.
//   Next clock flash=C000|~pc.
// - Same frame with CSUM=15: load_err=1, cpu_run=0, no load_done.
//   A subsequent good frame clears load_err and resumes.
// - CNT=0000 and CNT=0201: ERR right after CNTH; no memory writes.
// - Stall after CNTL for TIMEOUT clocks (bench TIMEOUT=16): load_err=1 at clock 16.
//   With a byte at clock 15 instead: no error.
// - Reset mid-frame after 1 word; byte 0x00 then HDR in RUN: only HDR starts a frame.
//   The word written before the reset is retained.

Source files
------------

// File: rtl/avr_progmem.sv
// Program-memory responder for the avr core: combinational fetch plus a UART-fed frame loader.
// Flash reads are zero-latency; the loader takes one byte per clock and only stalls during BOOT.
module avr_progmem #(
  parameter int          ADDR_W  = 9,
  parameter int          TIMEOUT = 1000000,
  parameter logic [7:0]  HDR     = 8'hA5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc,
  output logic [15:0]       flash,
  output logic              cpu_run,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int          DEPTH    = 2**ADDR_W;
  localparam logic [16:0] DEPTH_L  = 17'(DEPTH);
  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT - 1);

  localparam logic [2:0] S_BOOT = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_CNTL = 3'd2;
  localparam logic [2:0] S_CNTH = 3'd3;
  localparam logic [2:0] S_LO   = 3'd4;
  localparam logic [2:0] S_HI   = 3'd5;
  localparam logic [2:0] S_CSUM = 3'd6;
  localparam logic [2:0] S_ERR  = 3'd7;

  logic [2:0]        r_state;
  logic [15:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_waddr;
  logic [15:0]       r_cnt;
  logic [7:0]        r_lo;
  logic [7:0]        r_sum;
  logic [19:0]       r_timer;

  logic        w_accept;
  logic        w_loading;
  logic        w_mem_we;
  logic        w_timeout;
  logic        w_cnt_bad;
  logic [15:0] w_cnt_full;

  assign w_loading = (r_state == S_CNTL) || (r_state == S_CNTH) || (r_state == S_LO) ||
                     (r_state == S_HI)   || (r_state == S_CSUM);
  assign rx_ready  = (r_state != S_BOOT);
  assign w_accept  = rx_valid & rx_ready;
  assign cpu_run   = (r_state == S_BOOT) || (r_state == S_RUN);
  assign load_busy = w_loading;

  // BOOT injects an RJMP whose offset lands the core on address 0 from any pc.
  assign flash = (r_state == S_BOOT) ? {4'hC, {(12-ADDR_W){1'b0}}, ~pc} : r_mem[pc];

  assign w_cnt_full = {rx_data, r_cnt[7:0]};
  assign w_cnt_bad  = (w_cnt_full == 16'd0) || ({1'b0, w_cnt_full} > DEPTH_L);
  assign w_timeout  = w_loading && !w_accept && (r_timer == TMO_LAST);
  assign w_mem_we   = (r_state == S_HI) && w_accept;

  // No reset on the array: a mid-frame reset keeps whatever was already written.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[r_waddr] <= {rx_data, r_lo};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_BOOT;
      r_waddr   <= '0;
      r_cnt     <= '0;
      r_lo      <= '0;
      r_sum     <= '0;
      r_timer   <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      if (w_loading && !w_accept) begin
        r_timer <= r_timer + 20'd1;
      end else begin
        r_timer <= '0;
      end

      if (w_timeout) begin
        r_state  <= S_ERR;
        load_err <= 1'b1;
      end else begin
        case (r_state)
          S_BOOT: r_state <= S_RUN;
          S_RUN, S_ERR: begin
            if (w_accept && (rx_data == HDR)) begin
              load_err <= 1'b0;
              r_sum    <= '0;
              r_waddr  <= '0;
              r_state  <= S_CNTL;
            end
          end
          S_CNTL: begin
            if (w_accept) begin
              r_cnt[7:0] <= rx_data;
              r_state    <= S_CNTH;
            end
          end
          S_CNTH: begin
            if (w_accept) begin
              r_cnt[15:8] <= rx_data;
              if (w_cnt_bad) begin
                r_state  <= S_ERR;
                load_err <= 1'b1;
              end else begin
                r_state <= S_LO;
              end
            end
          end
          S_LO: begin
            if (w_accept) begin
              r_lo    <= rx_data;
              r_sum   <= r_sum + rx_data;
              r_state <= S_HI;
            end
          end
          S_HI: begin
            if (w_accept) begin
              r_sum   <= r_sum + rx_data;
              r_waddr <= r_waddr + 1'b1;
              r_cnt   <= r_cnt - 16'd1;
              r_state <= (r_cnt == 16'd1) ? S_CSUM : S_LO;
            end
          end
          S_CSUM: begin
            if (w_accept) begin
              if (rx_data == r_sum) begin
                load_done <= 1'b1;
                r_state   <= S_BOOT;
              end else begin
                load_err <= 1'b1;
                r_state  <= S_ERR;
              end
            end
          end
        endcase
      end
    end
  end

endmodule
